// File: rtl/key_debounce_if.sv
// Key conditioner bundle: raw pins in, debounced pulses and levels out.
// Drive key_in from the master side; key_debounce sits on the slave side.
interface key_debounce_if #(
  parameter int NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_up;
  logic [NUM_KEYS-1:0] key_level;

  modport master (output key_in, input key_down, input key_up, input key_level);
  modport slave  (input key_in, output key_down, output key_up, output key_level);
endinterface

// File: rtl/key_debounce.sv
// Per-key synchroniser + debounce FSM producing press/release pulses and a clean level.
// Define KEY_REPEAT_EN to add hold-to-auto-repeat key_down pulses.
module key_debounce_lane #(
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 32768,
  parameter int REPEAT_CYCLES   = 8192
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic down,
  output logic up,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic INACT = (KEY_ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 || HOLD_CYCLES < REPEAT_CYCLES) begin : g_bad_cfg
    $error("key_debounce_lane: invalid cycle parameters");
  end

  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          down_q, down_d;
  logic          up_q, up_d;
  logic          level_q, level_d;
  logic          act;

`ifdef KEY_REPEAT_EN
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES - 1);
  // Reloading to HOLD-REPEAT makes each later repeat land REPEAT cycles apart.
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);
  logic [HW-1:0] hold_q, hold_d;
`endif

  assign act = sync_q[1] ^ INACT;

  always_comb begin
    sync_d  = {sync_q[0], pin};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    down_d  = 1'b0;
    up_d    = 1'b0;
`ifdef KEY_REPEAT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (act) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!act) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          down_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!act) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (act) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          up_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef KEY_REPEAT_EN
    // Repeat pulses are suppressed on the release edge so down/up never coincide.
    if (state_q == PRESS_CHK && state_d == PRESSED) begin
      hold_d = '0;
    end else if ((state_q == PRESSED || state_q == REL_CHK) && state_d != IDLE) begin
      if (hold_q == HOLD_MAX) begin
        down_d = 1'b1;
        hold_d = HOLD_RELOAD;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end else if (state_d == IDLE) begin
      hold_d = '0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= {2{INACT}};
      state_q <= IDLE;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
      level_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      hold_q  <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
      up_q    <= up_d;
      level_q <= level_d;
`ifdef KEY_REPEAT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign down  = down_q;
  assign up    = up_q;
  assign level = level_q;
endmodule

module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 32768,
  parameter int REPEAT_CYCLES   = 8192
) (
  input  logic           clock,
  input  logic           reset,
  key_debounce_if.slave  kif
);
  logic [NUM_KEYS-1:0] down_w, up_w, level_w;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_lane (
      .clock(clock),
      .reset(reset),
      .pin  (kif.key_in[i]),
      .down (down_w[i]),
      .up   (up_w[i]),
      .level(level_w[i])
    );
  end

  assign kif.key_down  = down_w;
  assign kif.key_up    = up_w;
  assign kif.key_level = level_w;
endmodule
